// File: rtl/lcd_write_engine_pkg.sv
// lcd_write_engine_pkg: timing defaults, command codes and delay-load helper for the LCD write engine.
// LCD_INIT_SEQ_EN adds the power-on wait constants and widens the delay counter to hold them.
package lcd_write_engine_pkg;
    localparam int unsigned LCD_T_SETUP = 2;
    localparam int unsigned LCD_T_EHIGH = 12;
    localparam int unsigned LCD_T_GAP   = 50;
    localparam int unsigned LCD_T_CMD   = 2000;
    localparam int unsigned LCD_T_CLEAR = 82000;
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
`ifdef LCD_INIT_SEQ_EN
    localparam int unsigned LCD_T_INIT_PWR = 750000;
    localparam int unsigned LCD_T_INIT1    = 205000;
    localparam int unsigned LCD_T_INIT2    = 5000;
    localparam int unsigned LCD_T_INIT3    = 2000;
    localparam int CNT_W = 20;
`else
    localparam int CNT_W = 17;
`endif
    typedef logic [CNT_W-1:0] cnt_t;
    // A duration of 0 behaves like 1.
    function automatic cnt_t ld(input int unsigned n);
        return (n == 0) ? '0 : cnt_t'(n - 1);
    endfunction
endpackage

// File: rtl/lcd_write_engine_if.sv
// lcd_write_engine_if: CPU request handshake plus the 4-bit LCD pin bundle.
interface lcd_write_engine_if;
    logic       iValid;
    logic [7:0] iData;
    logic       iRS;
    logic       oReady;
    logic       oDone;
    logic [3:0] oLCD_Data;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    modport master (output iValid, iData, iRS, input oReady, oDone, oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW);
    modport slave  (input iValid, iData, iRS, output oReady, oDone, oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW);
endinterface

// File: rtl/lcd_write_engine_delay_counter.sv
// lcd_write_engine_delay_counter: down-counter reloaded by load, flags expiry when it sits at zero.
module lcd_write_engine_delay_counter
    import lcd_write_engine_pkg::*;
#(
    parameter cnt_t RST_VAL = '0
) (
    input  logic Clock,
    input  logic Reset,
    input  logic load,
    input  cnt_t load_val,
    output logic expired
);
    cnt_t cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - cnt_t'(1) : cnt_q);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) cnt_q <= RST_VAL;
        else        cnt_q <= cnt_d;
    end

    assign expired = cnt_q == '0;
endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: writes one byte + RS as two E-strobed nibbles with setup/pulse/gap/exec timing.
// Define LCD_INIT_SEQ_EN to run the LCD power-on nibble sequence after reset.
module lcd_write_engine
    import lcd_write_engine_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = LCD_T_SETUP,
    parameter int unsigned E_HIGH_CYC     = LCD_T_EHIGH,
    parameter int unsigned GAP_CYC        = LCD_T_GAP,
    parameter int unsigned CMD_WAIT_CYC   = LCD_T_CMD,
    parameter int unsigned CLEAR_WAIT_CYC = LCD_T_CLEAR
) (
    input logic Clock,
    input logic Reset,
    lcd_write_engine_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, SETUP_H, PULSE_H, GAP, SETUP_L, PULSE_L, WAIT
`ifdef LCD_INIT_SEQ_EN
        , INIT_WAIT, INIT_SETUP, INIT_PULSE
`endif
    } state_t;

`ifdef LCD_INIT_SEQ_EN
    localparam state_t ST_RST  = INIT_WAIT;
    localparam cnt_t   CNT_RST = ld(LCD_T_INIT_PWR);
    localparam logic   RDY_RST = 1'b0;
`else
    localparam state_t ST_RST  = IDLE;
    localparam cnt_t   CNT_RST = '0;
    localparam logic   RDY_RST = 1'b1;
`endif

    state_t     state_q, state_d, nxt;
    logic [7:0] byte_q, byte_d;
    logic [3:0] data_q, data_d;
    logic       rs_q, rs_d, ready_q, ready_d, done_q, done_d, e_q, e_d, rs_out_q, rs_out_d;
    logic       load, expired, is_clear;
    cnt_t       load_val;
`ifdef LCD_INIT_SEQ_EN
    logic [2:0] step_q, step_d;
`endif

    lcd_write_engine_delay_counter #(.RST_VAL(CNT_RST)) u_delay (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    assign is_clear = !rs_q && byte_q inside {LCD_CMD_CLEAR, LCD_CMD_HOME, LCD_CMD_CLEAR | LCD_CMD_HOME};

    // Every non-idle state leaves on counter expiry and reloads it for the state it enters.
    always_comb begin
        load     = state_q == IDLE ? bus.iValid : expired;
        load_val = ld(SETUP_CYC);
        nxt      = IDLE;
        unique case (state_q)
            IDLE:    nxt = SETUP_H;
            SETUP_H: begin nxt = PULSE_H; load_val = ld(E_HIGH_CYC); end
            PULSE_H: begin nxt = GAP; load_val = ld(GAP_CYC); end
            GAP:     nxt = SETUP_L;
            SETUP_L: begin nxt = PULSE_L; load_val = ld(E_HIGH_CYC); end
            PULSE_L: begin nxt = WAIT; load_val = is_clear ? ld(CLEAR_WAIT_CYC) : ld(CMD_WAIT_CYC); end
            WAIT:    nxt = IDLE;
`ifdef LCD_INIT_SEQ_EN
            INIT_WAIT:  nxt = step_q == 3'd4 ? IDLE : INIT_SETUP;
            INIT_SETUP: begin nxt = INIT_PULSE; load_val = ld(E_HIGH_CYC); end
            INIT_PULSE: begin
                nxt      = INIT_WAIT;
                load_val = ld(step_q == 3'd0 ? LCD_T_INIT1 : step_q == 3'd1 ? LCD_T_INIT2 : LCD_T_INIT3);
            end
`endif
            default: ;
        endcase
        state_d = load ? nxt : state_q;
        byte_d  = state_q == IDLE && load ? bus.iData : byte_q;
        rs_d    = state_q == IDLE && load ? bus.iRS : rs_q;
        ready_d = load ? nxt == IDLE : ready_q;
        done_d  = load && state_q == WAIT;
`ifdef LCD_INIT_SEQ_EN
        // Init nibbles ride in the high half so the normal high-nibble path drives them.
        if (state_q == INIT_WAIT && load) byte_d = {step_q == 3'd3 ? 4'h2 : 4'h3, 4'h0};
        step_d = state_q == INIT_PULSE && load ? step_q + 3'd1 : step_q;
        e_d    = state_q inside {PULSE_H, PULSE_L, INIT_PULSE};
`else
        e_d    = state_q inside {PULSE_H, PULSE_L};
`endif
        data_d   = state_q == IDLE ? data_q : !(state_q inside {SETUP_L, PULSE_L, WAIT}) ? byte_q[7:4] : byte_q[3:0];
        rs_out_d = state_q == IDLE ? rs_out_q : rs_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_RST;
            byte_q   <= '0;
            rs_q     <= 1'b0;
            ready_q  <= RDY_RST;
            done_q   <= 1'b0;
            e_q      <= 1'b0;
            data_q   <= '0;
            rs_out_q <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            step_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            e_q      <= e_d;
            data_q   <= data_d;
            rs_out_q <= rs_out_d;
`ifdef LCD_INIT_SEQ_EN
            step_q   <= step_d;
`endif
        end
    end

    assign bus.oReady    = ready_q;
    assign bus.oDone     = done_q;
    assign bus.oLCD_E    = e_q;
    assign bus.oLCD_RS   = rs_out_q;
    assign bus.oLCD_RW   = 1'b0;
    assign bus.oLCD_Data = data_q;
endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: randomized self-checking bench; a per-transfer timeline model predicts every output cycle.
module tb_lcd_write_engine;
    localparam int S = 2, H = 12, G = 50, CMD = 2000, CLR = 82000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0;

    lcd_write_engine_if bus();
    lcd_write_engine dut (.Clock(clk), .Reset(rst_n), .bus(bus));

    initial forever #5 clk = ~clk;

    bit         busy = 1'b0, m_done = 1'b0;
    int         t = 0, tot = 0;
    logic [7:0] b = '0;
    logic       r = 1'b0, pr = 1'b0;
    logic [3:0] pd = '0;

    // Model: t counts edges since the accepting edge; outputs are windows on t.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            busy = 1'b0; t = 0; m_done = 1'b0; pd = '0; pr = 1'b0;
        end else begin
            m_done = 1'b0;
            if (busy) begin
                t++;
                if (t == tot) begin busy = 1'b0; m_done = 1'b1; pd = b[3:0]; pr = r; end
            end else if (bus.iValid) begin
                busy = 1'b1; t = 0; b = bus.iData; r = bus.iRS;
                tot = 2*S + 2*H + G + ((!r && b >= 8'd1 && b <= 8'd3) ? CLR : CMD);
            end
        end
    end

    function automatic logic [8:0] expv();
        logic act = busy && t >= 1;
        logic e = busy && ((t >= S + 1 && t <= S + H) || (t >= 2*S + H + G + 1 && t <= 2*S + 2*H + G));
        return {!busy, m_done, e, act ? r : pr, 1'b0, act ? (t >= S + H + G + 1 ? b[3:0] : b[7:4]) : pd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n)
            chk("cycle {rdy,done,e,rs,rw,data}",
                32'({bus.oReady, bus.oDone, bus.oLCD_E, bus.oLCD_RS, bus.oLCD_RW, bus.oLCD_Data}), 32'(expv()));
    end

    int         nrise, done_j, low_cnt, first_ready;
    int         rise_j[2], hi_w[2];
    logic [3:0] rise_d[2];
    logic       rise_rs[2];

    // Sample one transfer; j = 0 is the sample right after the accepting edge.
    task automatic observe(input bit junk, input bit keep);
        int j = 0;
        logic pe = 1'b0;
        nrise = 0; low_cnt = 0; done_j = -1; hi_w = '{0, 0};
        while (done_j < 0 && j < 90000) begin
            @(negedge clk);
            if (j == 0) begin
                first_ready = int'(bus.oReady);
                if (!keep) bus.iValid = 1'b0;
            end
            if (!bus.oReady) low_cnt++;
            if (bus.oLCD_E && !pe) begin
                if (nrise < 2) begin rise_j[nrise] = j; rise_d[nrise] = bus.oLCD_Data; rise_rs[nrise] = bus.oLCD_RS; end
                nrise++;
            end
            if (bus.oLCD_E && nrise >= 1 && nrise <= 2) hi_w[nrise-1]++;
            if (bus.oDone) done_j = j;
            pe = bus.oLCD_E;
            if (junk && j > 0) begin
                bus.iValid = 1'($urandom_range(0, 1));
                bus.iData  = 8'($urandom);
                bus.iRS    = 1'($urandom);
            end
            j++;
        end
        if (junk) bus.iValid = 1'b0;
        if (done_j < 0) begin
            errors++;
            $display("FAIL done_timeout: no oDone within %0d cycles", j);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.oReady && n < 100000) begin @(negedge clk); n++; end
        if (!bus.oReady) begin
            errors++;
            $display("FAIL ready_timeout: oReady still 0 after %0d cycles", n);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic rs, input bit junk, input bit keep);
        wait_ready();
        bus.iValid = 1'b1; bus.iData = d; bus.iRS = rs;
        observe(junk, keep);
    endtask

    initial begin
        logic [7:0] rb;
        int n;
        bus.iValid = 1'b0; bus.iData = '0; bus.iRS = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'({bus.oReady, bus.oDone, bus.oLCD_E, bus.oLCD_RS, bus.oLCD_RW, bus.oLCD_Data}), 32'h100);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.oReady), 32'd1);

        send(8'h48, 1'b1, 1'b0, 1'b0);
        chk("48_first_rise", rise_j[0], 3);
        chk("48_second_rise", rise_j[1], 67);
        chk("48_pulses", nrise, 2);
        chk("48_width_h", hi_w[0], 12);
        chk("48_width_l", hi_w[1], 12);
        chk("48_nib_h", 32'(rise_d[0]), 32'h4);
        chk("48_nib_l", 32'(rise_d[1]), 32'h8);
        chk("48_rs", 32'({rise_rs[0], rise_rs[1]}), 32'h3);
        chk("48_done", done_j, 2078);

        send(8'h01, 1'b0, 1'b0, 1'b0);
        chk("clear_ready_low", low_cnt, 82078);
        chk("clear_done", done_j, 82078);

        send(8'h01, 1'b1, 1'b1, 1'b0);
        chk("01rs1_done", done_j, 2078);
        chk("01rs1_pulses", nrise, 2);
        chk("01rs1_nib_h", 32'(rise_d[0]), 32'h0);
        chk("01rs1_nib_l", 32'(rise_d[1]), 32'h1);

        send(8'h28, 1'b0, 1'b0, 1'b1);
        chk("b2b_first_done", done_j, 2078);
        send(8'h06, 1'b0, 1'b0, 1'b0);
        chk("b2b_no_gap", first_ready, 0);
        chk("b2b_second_done", done_j, 2078);
        chk("b2b_nibs", 32'({rise_d[0], rise_d[1]}), 32'h06);

        wait_ready();
        rb = 8'($urandom);
        bus.iValid = 1'b1; bus.iData = rb; bus.iRS = 1'b1;
        @(negedge clk);
        bus.iValid = 1'b0;
        n = 0;
        while (!bus.oLCD_E && n < 20) begin @(negedge clk); n++; end
        chk("abort_in_pulse", 32'(bus.oLCD_E), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("abort_e_async", 32'(bus.oLCD_E), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(bus.oReady), 32'd1);
        send(rb, 1'b1, 1'b0, 1'b0);
        chk("abort_rerun_done", done_j, 2078);
        chk("abort_rerun_nibs", 32'({rise_d[0], rise_d[1]}), 32'(rb));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
